l298n_ramp_ctrl: RTL and testbench



---
 rtl/l298n_ctrl_pkg.sv | 26 ++
 rtl/l298n_tick_gen.sv | 22 ++
 rtl/l298n_ramp_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_l298n_ramp_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l298n_ctrl_pkg.sv
// Shared definitions for the L298N ramp controller: FSM states, register
// addresses and register bit positions.
package l298n_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_DEAD     = 3'd2,
    ST_STOPPING = 3'd3,
    ST_ESTOP    = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_TARGET = 2'd1;
  localparam logic [1:0] ADDR_STEP   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  localparam int STAT_STATE_LSB  = 0;
  localparam int STAT_ESTOP_BIT  = 3;
  localparam int STAT_AT_TGT_BIT = 4;
  localparam int STAT_DUTY_LSB   = 8;

endpackage

// File: rtl/l298n_tick_gen.sv
// Free-running ramp tick: one-cycle pulse every TICK_DIV clocks.
module l298n_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] r_cnt;

  assign tick = (r_cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     r_cnt <= '0;
    else if (tick) r_cnt <= '0;
    else           r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/l298n_ramp_ctrl.sv
// Avalon-MM motion sequencer: slews PWM duty toward a signed target, inserts
// coast dead-time on reversal and latches an emergency stop from a button.
module l298n_ramp_ctrl
  import l298n_ctrl_pkg::*;
#(
  parameter int DUTY_W     = 8,
  parameter int TICK_DIV   = 50000,
  parameter int DEAD_TICKS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic              estop_btn,
  output logic [DUTY_W-1:0] pwm_duty,
  output logic              pwm_dir,
  output logic              pwm_en,
  output logic              pwm_brake
);

  localparam int DEAD_W = $clog2(DEAD_TICKS + 1);

  state_t              r_state, w_state_next;
  logic                r_enable, w_enable_next;
  logic [DUTY_W-1:0]   r_tgt_mag, r_step, r_duty, w_duty_next;
  logic                r_tgt_dir, r_dir, w_dir_next;
  logic                r_en, r_brake, r_latched, w_latched_next;
  logic [DEAD_W-1:0]   r_dead_cnt, w_dead_next;
  logic [1:0]          r_sync;
  logic                r_sync_d;
  logic [31:0]         r_readdata, w_rd;
  logic                w_tick, w_estop_edge, w_wr_ctrl, w_clear, w_at_target;
  logic [DUTY_W-1:0]   w_step_eff;
  logic                w_unused;

  // Move cur toward tgt by at most stp, landing exactly on tgt.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt,
                                                    input logic [DUTY_W-1:0] stp);
    if (cur < tgt)      return ((tgt - cur) > stp) ? cur + stp : tgt;
    else if (cur > tgt) return ((cur - tgt) > stp) ? cur - stp : tgt;
    else                return cur;
  endfunction

  l298n_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_unused     = &{1'b0, avs_writedata[31:DUTY_W+1]};
  assign w_estop_edge = r_sync[1] & ~r_sync_d;
  assign w_wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
  assign w_clear      = w_wr_ctrl && avs_writedata[CTRL_CLR_BIT];
  assign w_step_eff   = (r_step == '0) ? DUTY_W'(1) : r_step;
  assign w_at_target  = (r_state == ST_RUN) && (r_dir == r_tgt_dir) && (r_duty == r_tgt_mag);

  always_comb begin
    w_state_next   = r_state;
    w_duty_next    = r_duty;
    w_dir_next     = r_dir;
    w_latched_next = r_latched;
    w_dead_next    = r_dead_cnt;
    w_enable_next  = r_enable;
    if (w_wr_ctrl) w_enable_next = avs_writedata[CTRL_EN_BIT];

    case (r_state)
      ST_IDLE: begin
        w_duty_next = '0;
        if (r_enable && !r_latched) begin
          w_state_next = ST_RUN;
          w_dir_next   = r_tgt_dir;
        end
      end
      ST_RUN: begin
        if (!r_enable) begin
          w_state_next = ST_STOPPING;
        end else if (w_tick) begin
          if (r_dir == r_tgt_dir) begin
            w_duty_next = step_toward(r_duty, r_tgt_mag, w_step_eff);
          end else if (r_duty != '0) begin
            w_duty_next = step_toward(r_duty, '0, w_step_eff);
          end else begin
            w_state_next = ST_DEAD;
            w_dead_next  = DEAD_W'(DEAD_TICKS);
          end
        end
      end
      ST_DEAD: begin
        w_duty_next = '0;
        if (!r_enable) begin
          w_state_next = ST_IDLE;
        end else if (r_dead_cnt == '0) begin
          w_state_next = ST_RUN;
          w_dir_next   = r_tgt_dir;
        end else if (w_tick) begin
          w_dead_next = r_dead_cnt - DEAD_W'(1);
        end
      end
      ST_STOPPING: begin
        if (r_enable)            w_state_next = ST_RUN;
        else if (r_duty == '0)   w_state_next = ST_IDLE;
        else if (w_tick)         w_duty_next  = step_toward(r_duty, '0, w_step_eff);
      end
      ST_ESTOP: begin
        w_duty_next = '0;
        // Only re-arm once the operator has let go of the button.
        if (w_clear && !r_sync[1]) begin
          w_state_next   = ST_IDLE;
          w_latched_next = 1'b0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (w_estop_edge) begin
      w_state_next   = ST_ESTOP;
      w_duty_next    = '0;
      w_latched_next = 1'b1;
      w_enable_next  = 1'b0;
    end
  end

  always_comb begin
    w_rd = '0;
    case (avs_address)
      ADDR_CTRL:   w_rd[CTRL_EN_BIT] = r_enable;
      ADDR_TARGET: begin
        w_rd[DUTY_W-1:0] = r_tgt_mag;
        w_rd[DUTY_W]     = r_tgt_dir;
      end
      ADDR_STEP:   w_rd[DUTY_W-1:0] = r_step;
      default: begin
        w_rd[STAT_STATE_LSB +: 3]       = r_state;
        w_rd[STAT_ESTOP_BIT]            = r_latched;
        w_rd[STAT_AT_TGT_BIT]           = w_at_target;
        w_rd[STAT_DUTY_LSB +: DUTY_W]   = r_duty;
        w_rd[STAT_DUTY_LSB + DUTY_W]    = r_dir;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_enable   <= 1'b0;
      r_tgt_mag  <= '0;
      r_tgt_dir  <= 1'b0;
      r_step     <= '0;
      r_duty     <= '0;
      r_dir      <= 1'b0;
      r_en       <= 1'b0;
      r_brake    <= 1'b0;
      r_latched  <= 1'b0;
      r_dead_cnt <= '0;
      r_sync     <= '0;
      r_sync_d   <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_sync     <= {r_sync[0], estop_btn};
      r_sync_d   <= r_sync[1];
      r_state    <= w_state_next;
      r_enable   <= w_enable_next;
      r_duty     <= w_duty_next;
      r_dir      <= w_dir_next;
      r_latched  <= w_latched_next;
      r_dead_cnt <= w_dead_next;
      r_en       <= (w_state_next == ST_RUN) || (w_state_next == ST_STOPPING);
      r_brake    <= (w_state_next == ST_ESTOP);
      if (avs_write && avs_address == ADDR_TARGET) begin
        r_tgt_mag <= avs_writedata[DUTY_W-1:0];
        r_tgt_dir <= avs_writedata[DUTY_W];
      end
      if (avs_write && avs_address == ADDR_STEP) r_step <= avs_writedata[DUTY_W-1:0];
      if (avs_read) r_readdata <= w_rd;
    end
  end

  assign avs_readdata = r_readdata;
  assign pwm_duty     = r_duty;
  assign pwm_dir      = r_dir;
  assign pwm_en       = r_en;
  assign pwm_brake    = r_brake;

endmodule

// File: tb/tb_l298n_ramp_ctrl.sv
// Scoreboard bench for l298n_ramp_ctrl: expected output transitions are queued
// as stimulus is applied and checked as the PWM outputs change.
module tb_l298n_ramp_ctrl;

  typedef struct packed {
    logic       brake;
    logic       en;
    logic       dir;
    logic [7:0] duty;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        estop_btn = 1'b0;
  logic [7:0]  pwm_duty;
  logic        pwm_dir, pwm_en, pwm_brake;

  obs_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          en_fall_cyc = 0;
  int          en_rise_cyc = 0;
  bit          mon_en = 1'b0;
  obs_t        mon_last;

  l298n_ramp_ctrl #(.DUTY_W(8), .TICK_DIV(4), .DEAD_TICKS(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .estop_btn     (estop_btn),
    .pwm_duty      (pwm_duty),
    .pwm_dir       (pwm_dir),
    .pwm_en        (pwm_en),
    .pwm_brake     (pwm_brake)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every change of the PWM outputs pops one expectation.
  always @(negedge clk) begin
    obs_t cur, e;
    cur = {pwm_brake, pwm_en, pwm_dir, pwm_duty};
    if (mon_en && cur !== mon_last) begin
      if (!mon_last.en && cur.en) en_rise_cyc = cyc;
      if (mon_last.en && !cur.en) en_fall_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pwm_change: got brake=%0b en=%0b dir=%0b duty=%0d, required no change",
                 cur.brake, cur.en, cur.dir, cur.duty);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          miscompares++;
          $display("FAIL pwm_change: got brake=%0b en=%0b dir=%0b duty=%0d, required brake=%0b en=%0b dir=%0b duty=%0d",
                   cur.brake, cur.en, cur.dir, cur.duty, e.brake, e.en, e.dir, e.duty);
        end else begin
          $display("pwm  brake=%0b en=%0b dir=%0b duty=%0d ok", cur.brake, cur.en, cur.dir, cur.duty);
        end
      end
      mon_last = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(input logic b, input logic e, input logic d, input int duty);
    return {b, e, d, 8'(duty)};
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL %s_timeout: %0d expected transitions still pending, required 0", name, exp_q.size());
    exp_q.delete();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    estop_btn = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    mon_last = {pwm_brake, pwm_en, pwm_dir, pwm_duty};
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    do_reset();
    vectors++;
    if ({pwm_brake, pwm_en, pwm_dir, pwm_duty} !== 11'd0 || avs_readdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got brake=%0b en=%0b dir=%0b duty=%0d rd=%h, required all 0",
               pwm_brake, pwm_en, pwm_dir, pwm_duty, avs_readdata);
    end
    for (int a = 0; a < 4; a++) begin
      rd_q.push_back(32'd0);
      bus_read(2'(a), d);
      e = rd_q.pop_front();
      vectors++;
      if (d !== e) begin
        miscompares++;
        $display("FAIL reset_reg%0d: got %h, required %h", a, d, e);
      end else $display("read reg%0d = %h ok", a, d);
    end
  endtask

  task automatic test_ramp_up();
    logic [31:0] d, e;
    do_reset();
    bus_write(2'd2, 32'd10);
    bus_write(2'd1, 32'd25);
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 10));
    exp_q.push_back(mk(0, 1, 0, 20));
    exp_q.push_back(mk(0, 1, 0, 25));
    bus_write(2'd0, 32'd1);
    drain("ramp_up");
    repeat (16) @(posedge clk);
    rd_q.push_back(32'h0000_1911);
    bus_read(2'd3, d);
    e = rd_q.pop_front();
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL ramp_status: got %h, required %h", d, e);
    end else $display("read status = %h ok", d);
  endtask

  task automatic test_reversal();
    logic [31:0] d, e;
    int dead_len;
    exp_q.push_back(mk(0, 1, 0, 15));
    exp_q.push_back(mk(0, 1, 0, 5));
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 1, 0));
    exp_q.push_back(mk(0, 1, 1, 10));
    exp_q.push_back(mk(0, 1, 1, 15));
    bus_write(2'd1, 32'h0000_010F);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!pwm_en) break;
    end
    rd_q.push_back(32'h0000_0002);
    bus_read(2'd3, d);
    e = rd_q.pop_front();
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL dead_status: got %h, required %h", d, e);
    end else $display("read status = %h ok", d);
    drain("reversal");
    dead_len = en_rise_cyc - en_fall_cyc;
    vectors++;
    if (dead_len < 8 || dead_len > 12) begin
      miscompares++;
      $display("FAIL dead_time: got %0d cycles with en=0, required 8..12", dead_len);
    end else $display("dead time %0d cycles ok", dead_len);
    rd_q.push_back(32'h0001_0F11);
    bus_read(2'd3, d);
    e = rd_q.pop_front();
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL reversal_status: got %h, required %h", d, e);
    end else $display("read status = %h ok", d);
  endtask

  task automatic test_stop();
    logic [31:0] d, e;
    do_reset();
    bus_write(2'd2, 32'd10);
    bus_write(2'd1, 32'd25);
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 10));
    exp_q.push_back(mk(0, 1, 0, 20));
    exp_q.push_back(mk(0, 1, 0, 25));
    bus_write(2'd0, 32'd1);
    drain("stop_ramp");
    exp_q.push_back(mk(0, 1, 0, 15));
    exp_q.push_back(mk(0, 1, 0, 5));
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    bus_write(2'd0, 32'd0);
    drain("stop");
    rd_q.push_back(32'd0);
    bus_read(2'd3, d);
    e = rd_q.pop_front();
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL stop_status: got %h, required %h", d, e);
    end else $display("read status = %h ok", d);
  endtask

  task automatic test_estop();
    logic [31:0] d, e;
    int lat;
    do_reset();
    bus_write(2'd2, 32'd100);
    bus_write(2'd1, 32'd200);
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 100));
    exp_q.push_back(mk(0, 1, 0, 200));
    bus_write(2'd0, 32'd1);
    drain("estop_ramp");
    exp_q.push_back(mk(1, 0, 0, 0));
    @(posedge clk); #1 estop_btn = 1'b1;
    lat = 99;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (pwm_brake) begin lat = i; break; end
    end
    vectors++;
    if (lat > 3) begin
      miscompares++;
      $display("FAIL estop_latency: got %0d cycles, required <= 3", lat);
    end else $display("estop latency %0d cycles ok", lat);
    drain("estop");
    rd_q.push_back(32'h0000_000C);
    bus_read(2'd3, d);
    e = rd_q.pop_front();
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL estop_status: got %h, required %h", d, e);
    end else $display("read status = %h ok", d);
    rd_q.push_back(32'd0);
    bus_read(2'd0, d);
    e = rd_q.pop_front();
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL estop_ctrl: got %h, required %h", d, e);
    end else $display("read ctrl = %h ok", d);
    bus_write(2'd0, 32'd2);
    rd_q.push_back(32'h0000_000C);
    bus_read(2'd3, d);
    e = rd_q.pop_front();
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL estop_clear_held: got %h, required %h", d, e);
    end else $display("read status = %h ok", d);
    estop_btn = 1'b0;
    repeat (4) @(posedge clk);
    exp_q.push_back(mk(0, 0, 0, 0));
    bus_write(2'd0, 32'd2);
    drain("estop_clear");
    rd_q.push_back(32'd0);
    bus_read(2'd3, d);
    e = rd_q.pop_front();
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL estop_cleared: got %h, required %h", d, e);
    end else $display("read status = %h ok", d);
  endtask

  task automatic test_simultaneous();
    logic [31:0] d, e;
    do_reset();
    exp_q.push_back(mk(1, 0, 0, 0));
    @(posedge clk); #1 estop_btn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    avs_address = 2'd0; avs_writedata = 32'd1; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
    drain("simul");
    rd_q.push_back(32'd0);
    bus_read(2'd0, d);
    e = rd_q.pop_front();
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL simul_ctrl: got %h, required %h", d, e);
    end else $display("read ctrl = %h ok", d);
    rd_q.push_back(32'h0000_000C);
    bus_read(2'd3, d);
    e = rd_q.pop_front();
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL simul_status: got %h, required %h", d, e);
    end else $display("read status = %h ok", d);
    estop_btn = 1'b0;
  endtask

  task automatic test_edge_cases();
    logic [31:0] d, e;
    do_reset();
    bus_write(2'd2, 32'd0);
    bus_write(2'd1, 32'd3);
    for (int v = 0; v <= 3; v++) exp_q.push_back(mk(0, 1, 0, v));
    bus_write(2'd0, 32'd1);
    drain("step_zero");
    bus_write(2'd2, 32'd10);
    for (int v = 13; v <= 243; v += 10) exp_q.push_back(mk(0, 1, 0, v));
    exp_q.push_back(mk(0, 1, 0, 250));
    bus_write(2'd1, 32'd250);
    drain("ramp_250");
    exp_q.push_back(mk(0, 1, 0, 255));
    bus_write(2'd1, 32'd255);
    drain("sat_255");
    rd_q.push_back(32'h0000_FF11);
    bus_read(2'd3, d);
    e = rd_q.pop_front();
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL sat_status: got %h, required %h", d, e);
    end else $display("read status = %h ok", d);
    mon_en = 1'b0;
    bus_write(2'd1, 32'd0);
    repeat (10) @(posedge clk);
    bus_read(2'd3, d);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({pwm_brake, pwm_en, pwm_dir, pwm_duty} !== 11'd0 || avs_readdata !== 32'd0) begin
      miscompares++;
      $display("FAIL midramp_reset: got brake=%0b en=%0b dir=%0b duty=%0d rd=%h, required all 0",
               pwm_brake, pwm_en, pwm_dir, pwm_duty, avs_readdata);
    end else $display("mid-ramp reset outputs 0 ok");
    reset = 1'b0;
    rd_q.push_back(32'd0);
    bus_read(2'd3, d);
    e = rd_q.pop_front();
    vectors++;
    if (d !== e) begin
      miscompares++;
      $display("FAIL post_reset_status: got %h, required %h", d, e);
    end else $display("read status = %h ok", d);
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_stop();
    test_estop();
    test_simultaneous();
    test_edge_cases();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
